// File: rtl/free_record_mode_pkg.sv
// Shared definitions for the free-play record/playback mode.
// Holds the mode state encoding, the default key/length/octave geometry
// and the event record layout {octave, note, len} used on the sound
// interface and in the record buffer.
package free_record_mode_pkg;

  localparam int DEF_NOTE_KEYS   = 7;
  localparam int DEF_LEN_BITS    = 2;
  localparam int DEF_OCT_BITS    = 3;
  localparam int DEF_OCT_MIN     = 1;
  localparam int DEF_OCT_MAX     = 7;
  localparam int DEF_OCT_DEFAULT = 4;
  localparam int DEF_NOTE_BITS   = $clog2(DEF_NOTE_KEYS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } mode_state_e;

  // Event record, most significant field first. Top-level code packs
  // the same order into flat vectors so non-default widths still work.
  typedef struct packed {
    logic [DEF_OCT_BITS-1:0]  octave;
    logic [DEF_NOTE_BITS-1:0] note;
    logic [DEF_LEN_BITS-1:0]  len;
  } note_evt_t;

endpackage

// File: rtl/free_record_mode_note_buffer.sv
// Record buffer: DEPTH x W register array with an append pointer that
// doubles as the entry count, plus a full flag.
//   clk, rst     : clock, synchronous active-high reset (count only)
//   clr          : empty the buffer (count -> 0)
//   wr_en/wr_data: append one entry; ignored when full
//   rd_addr      : combinational read address; rd_data: entry at rd_addr
//   count        : stored entries (0..DEPTH); full: count == DEPTH
module note_buffer
  import free_record_mode_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full
);

  logic [W-1:0] mem [DEPTH];
  logic         do_wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full && !clr;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (clr)   count <= '0;
    else if (do_wr) count <= count + 1'b1;
  end

  // Storage is not reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[count[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/free_record_mode.sv
// Free-play mode with note recording and playback.
// Converts debounced key/octave/length inputs into sound events, records
// accepted events while in RECORD and replays them in PLAY.
// Build option: define LOOP_PLAY_EN to make PLAY wrap to the first entry
// and repeat until stop or en low; otherwise PLAY is a single pass.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : mode enable (low forces IDLE, blocks events)
//   hit, note_key, length_key: play request level, keys, length code
//   oct_up, oct_down         : octave adjust levels (rising edge acts)
//   rec_start, play_start, stop : single-cycle mode control pulses
//   snd_valid/snd_ready      : event handshake to sound unit
//   snd_octave/snd_note/snd_len : event fields, stable while valid
//   snd_done                 : sound unit finished current note
//   led                      : one-hot of sounding note
//   state_o                  : IDLE=0, RECORD=1, PLAY=2
//   rec_count, buf_full      : record buffer occupancy
module free_record_mode
  import free_record_mode_pkg::*;
#(
  parameter int NOTE_KEYS   = DEF_NOTE_KEYS,
  parameter int LEN_BITS    = DEF_LEN_BITS,
  parameter int OCT_BITS    = DEF_OCT_BITS,
  parameter int OCT_MIN     = DEF_OCT_MIN,
  parameter int OCT_MAX     = DEF_OCT_MAX,
  parameter int OCT_DEFAULT = DEF_OCT_DEFAULT,
  parameter int DEPTH       = 64,
  localparam int NOTE_BITS  = $clog2(NOTE_KEYS + 1),
  localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 hit,
  input  logic [NOTE_KEYS-1:0] note_key,
  input  logic [LEN_BITS-1:0]  length_key,
  input  logic                 oct_up,
  input  logic                 oct_down,
  input  logic                 rec_start,
  input  logic                 play_start,
  input  logic                 stop,
  output logic                 snd_valid,
  input  logic                 snd_ready,
  output logic [OCT_BITS-1:0]  snd_octave,
  output logic [NOTE_BITS-1:0] snd_note,
  output logic [LEN_BITS-1:0]  snd_len,
  input  logic                 snd_done,
  output logic [NOTE_KEYS-1:0] led,
  output logic [1:0]           state_o,
  output logic [CNT_BITS-1:0]  rec_count,
  output logic                 buf_full
);

  localparam int AW    = CNT_BITS - 1;
  localparam int EVT_W = OCT_BITS + NOTE_BITS + LEN_BITS;

`ifdef LOOP_PLAY_EN
  localparam bit LOOP_PLAY = 1'b1;
`else
  localparam bit LOOP_PLAY = 1'b0;
`endif

  mode_state_e state_q, state_d;

  logic                 hit_q, up_q, dn_q;
  logic                 hit_e, up_e, dn_e;
  logic [OCT_BITS-1:0]  octave_q;
  logic                 out_q;      // event issued, snd_done not yet seen
  logic [CNT_BITS-1:0]  ptr_q;
  logic [NOTE_BITS-1:0] key_note;
  logic [EVT_W-1:0]     rd_data;
  logic                 accept, done_evt, last_done;
  logic                 issue_live, issue_play, buf_wr, buf_clr, play_exit;

  assign hit_e = hit & ~hit_q;
  assign up_e  = oct_up & ~up_q;
  assign dn_e  = oct_down & ~dn_q;

  assign accept    = snd_valid & snd_ready;
  assign done_evt  = snd_done & out_q;
  assign last_done = done_evt && (ptr_q + 1'b1 == rec_count);

  // Lowest set key wins; note code is key index + 1.
  always_comb begin
    key_note = '0;
    for (int i = NOTE_KEYS - 1; i >= 0; i--)
      if (note_key[i]) key_note = NOTE_BITS'(i + 1);
  end

  always_comb begin
    state_d = state_q;
    if (!en) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: begin
          if (stop)                                state_d = ST_IDLE;
          else if (rec_start)                      state_d = ST_RECORD;
          else if (play_start && rec_count != '0)  state_d = ST_PLAY;
        end
        ST_RECORD: if (stop) state_d = ST_IDLE;
        ST_PLAY: begin
          if (stop)                         state_d = ST_IDLE;
          else if (last_done && !LOOP_PLAY) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

  assign issue_live = en && state_q != ST_PLAY && state_d != ST_PLAY &&
                      hit_e && (|note_key) && !out_q;
  assign issue_play = state_q == ST_PLAY && state_d == ST_PLAY && !out_q;
  assign play_exit  = state_q == ST_PLAY && state_d != ST_PLAY;
  assign buf_wr     = en && state_q == ST_RECORD && accept;
  assign buf_clr    = state_q == ST_IDLE && state_d == ST_RECORD;

  always_ff @(posedge clk) begin
    // History follows the inputs even during reset, so a level held
    // through reset is not seen as an edge afterwards.
    hit_q <= hit;
    up_q  <= oct_up;
    dn_q  <= oct_down;
    if (rst) begin
      octave_q   <= OCT_BITS'(OCT_DEFAULT);
      snd_valid  <= 1'b0;
      snd_octave <= '0;
      snd_note   <= '0;
      snd_len    <= '0;
      led        <= '0;
      out_q      <= 1'b0;
      ptr_q      <= '0;
    end else begin
      // Simultaneous up and down cancel.
      if (en && state_q != ST_PLAY && (up_e ^ dn_e)) begin
        if (up_e && octave_q != OCT_BITS'(OCT_MAX))      octave_q <= octave_q + 1'b1;
        else if (dn_e && octave_q != OCT_BITS'(OCT_MIN)) octave_q <= octave_q - 1'b1;
      end

      if (state_q == ST_IDLE && state_d == ST_PLAY) ptr_q <= '0;
      else if (state_q == ST_PLAY && done_evt)
        ptr_q <= last_done ? '0 : ptr_q + 1'b1;

      // Leaving PLAY abandons the in-flight note, so a late snd_done
      // must not count against anything.
      if (!en || play_exit) begin
        snd_valid <= 1'b0;
        out_q     <= 1'b0;
      end else if (issue_live || issue_play) begin
        snd_valid <= 1'b1;
        out_q     <= 1'b1;
        {snd_octave, snd_note, snd_len} <= issue_play ? rd_data
                                           : {octave_q, key_note, length_key};
      end else begin
        if (accept)   snd_valid <= 1'b0;
        if (done_evt) out_q     <= 1'b0;
      end

      if (!en || stop) led <= '0;
      else if (accept) led <= {{(NOTE_KEYS-1){1'b0}}, 1'b1} << (snd_note - 1'b1);
      else if (done_evt) led <= '0;
    end
  end

  note_buffer #(.DEPTH(DEPTH), .W(EVT_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data ({snd_octave, snd_note, snd_len}),
    .rd_addr (ptr_q[AW-1:0]),
    .rd_data (rd_data),
    .count   (rec_count),
    .full    (buf_full)
  );

endmodule

// File: tb/tb_free_record_mode.sv
// Scoreboard bench for free_record_mode (DEPTH=4 build). Expected sound
// events {octave, note, len} are queued by the stimulus; a negedge
// monitor pops and compares on every accepted handshake.
module tb_free_record_mode;

  localparam int NK = 7, LB = 2, OB = 3, NB = 3, DEPTH = 4, CB = 3;

  logic          clk = 1'b0;
  logic          rst, en, hit, oct_up, oct_down;
  logic          rec_start, play_start, stop, snd_ready, snd_done;
  logic [NK-1:0] note_key;
  logic [LB-1:0] length_key;
  logic          snd_valid;
  logic [OB-1:0] snd_octave;
  logic [NB-1:0] snd_note;
  logic [LB-1:0] snd_len;
  logic [NK-1:0] led;
  logic [1:0]    state_o;
  logic [CB-1:0] rec_count;
  logic          buf_full;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  free_record_mode #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .note_key(note_key),
    .length_key(length_key), .oct_up(oct_up), .oct_down(oct_down),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .snd_valid(snd_valid), .snd_ready(snd_ready), .snd_octave(snd_octave),
    .snd_note(snd_note), .snd_len(snd_len), .snd_done(snd_done),
    .led(led), .state_o(state_o), .rec_count(rec_count), .buf_full(buf_full)
  );

  // Monitor: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && snd_valid && snd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event: unexpected oct=%0d note=%0d len=%0d", snd_octave, snd_note, snd_len);
      end else begin
        e = exp_q.pop_front();
        if ({snd_octave, snd_note, snd_len} !== e) begin
          bad++;
          $display("FAIL event: got oct=%0d note=%0d len=%0d want oct=%0d note=%0d len=%0d",
                   snd_octave, snd_note, snd_len, e[7:5], e[4:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rec();  rec_start = 1; tick(); rec_start = 0; endtask
  task automatic pulse_play(); play_start = 1; tick(); play_start = 0; endtask
  task automatic pulse_stop(); stop = 1; tick(); stop = 0; endtask
  task automatic pulse_done(); snd_done = 1; tick(); snd_done = 0; endtask
  task automatic pulse_up();   oct_up = 1; tick(); oct_up = 0; tick(); endtask
  task automatic pulse_down(); oct_down = 1; tick(); oct_down = 0; tick(); endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!snd_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, snd_valid, 1);
  endtask

  // Live note: hit edge, accept, check led, finish.
  task automatic live_note(input logic [6:0] key, input logic [1:0] len,
                           input logic [2:0] oct, input logic [2:0] note);
    logic [6:0] oh;
    exp_q.push_back({oct, note, len});
    note_key = key; length_key = len; hit = 1;
    tick();
    hit = 0;
    wait_valid("live valid");
    snd_ready = 1; tick(); snd_ready = 0;
    oh = 7'd1 << (note - 1);
    chk("live led", led, oh);
    pulse_done();
  endtask

  // Playback entry: must not advance until snd_done.
  task automatic play_accept();
    wait_valid("play valid");
    snd_ready = 1; tick(); snd_ready = 0;
    tick();
    chk("play waits done", snd_valid, 0);
    pulse_done();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 1; hit = 0; oct_up = 1; oct_down = 0;
    rec_start = 0; play_start = 0; stop = 0; snd_ready = 0; snd_done = 0;
    note_key = '0; length_key = '0;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    chk("reset state", state_o, 0);
    chk("reset valid", snd_valid, 0);
    chk("reset led", led, 0);
    chk("reset count", rec_count, 0);
    chk("reset full", buf_full, 0);
    chk("reset fields", {snd_octave, snd_note, snd_len}, 0);
    oct_up = 0; tick();

    // Held oct_up through reset must leave octave at 4; ready stalled.
    exp_q.push_back({3'd4, 3'd3, 2'd2});
    note_key = 7'b0000100; length_key = 2; hit = 1;
    tick();
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall hold", {snd_valid, snd_octave, snd_note, snd_len}, {1'b1, 3'd4, 3'd3, 2'd2});
      tick();
    end
    chk("led before accept", led, 0);
    snd_ready = 1; tick(); snd_ready = 0;
    chk("led after accept", led, 7'b0000100);
    chk("valid after accept", snd_valid, 0);
    // Hit while outstanding is dropped.
    note_key = 7'b0000001; hit = 1; tick(); hit = 0; tick();
    chk("outstanding hit dropped", snd_valid, 0);
    chk("count unchanged", rec_count, 0);
    pulse_done();
    chk("led after done", led, 0);

    // Octave saturation and cancel.
    pulse_up(); pulse_up(); pulse_up();
    live_note(7'b0000001, 2'd0, 3'd7, 3'd1);
    pulse_up();
    live_note(7'b1000000, 2'd1, 3'd7, 3'd7);
    pulse_down();
    oct_up = 1; oct_down = 1; tick(); oct_up = 0; oct_down = 0; tick();
    note_key = '0; hit = 1; tick(); hit = 0; tick();
    chk("zero key dropped", snd_valid, 0);

    // Record three notes at octave 6, then play back.
    pulse_rec();
    chk("record state", state_o, 1);
    chk("record count clear", rec_count, 0);
    live_note(7'b0000001, 2'd0, 3'd6, 3'd1);
    live_note(7'b0010000, 2'd1, 3'd6, 3'd5);
    live_note(7'b1000000, 2'd3, 3'd6, 3'd7);
    chk("record count 3", rec_count, 3);
    pulse_stop();
    chk("stop to idle", state_o, 0);
    chk("count kept", rec_count, 3);
    exp_q.push_back({3'd6, 3'd1, 2'd0});
    exp_q.push_back({3'd6, 3'd5, 2'd1});
    exp_q.push_back({3'd6, 3'd7, 2'd3});
    pulse_play();
    chk("play state", state_o, 2);
    repeat (3) play_accept();
    chk("single pass end", state_o, 0);

    // Overfill a 4-entry buffer; all six still sound.
    pulse_rec();
    live_note(7'b1100010, 2'd0, 3'd6, 3'd2);
    live_note(7'b0001000, 2'd1, 3'd6, 3'd4);
    live_note(7'b0100000, 2'd2, 3'd6, 3'd6);
    live_note(7'b0000001, 2'd3, 3'd6, 3'd1);
    live_note(7'b0000100, 2'd0, 3'd6, 3'd3);
    live_note(7'b0010000, 2'd1, 3'd6, 3'd5);
    chk("full count", rec_count, 4);
    chk("full flag", buf_full, 1);
    pulse_stop();

    // Stop while an unaccepted playback event is pending.
    pulse_play();
    wait_valid("stop-case valid");
    chk("first entry note", snd_note, 2);
    pulse_stop();
    chk("stop drops valid", snd_valid, 0);
    chk("stop to idle 2", state_o, 0);
    pulse_done();
    tick();
    chk("late done ignored", {state_o, snd_valid}, 0);
    // Stop after acceptance clears led.
    exp_q.push_back({3'd6, 3'd2, 2'd0});
    pulse_play();
    wait_valid("stop-led valid");
    snd_ready = 1; tick(); snd_ready = 0;
    chk("play led", led, 7'b0000010);
    pulse_stop();
    chk("stop clears led", led, 0);

    // en low forces IDLE; empty buffer play_start is ignored.
    pulse_rec();
    chk("record again", state_o, 1);
    en = 0; tick();
    chk("en low idle", state_o, 0);
    en = 1;
    pulse_play();
    chk("empty play ignored", state_o, 0);

`ifdef LOOP_PLAY_EN
    pulse_rec();
    live_note(7'b0000010, 2'd2, 3'd6, 3'd2);
    live_note(7'b0001000, 2'd3, 3'd6, 3'd4);
    pulse_stop();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) exp_q.push_back({3'd6, 3'd2, 2'd2});
      else            exp_q.push_back({3'd6, 3'd4, 2'd3});
    end
    pulse_play();
    repeat (5) play_accept();
    chk("loop still playing", state_o, 2);
    wait_valid("loop valid");
    pulse_stop();
    chk("loop stop", {state_o, snd_valid}, 0);
`endif

    repeat (3) tick();
    chk("queue drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
